// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute/writeback sequencer feeding a combinational 8-bit ALU.
// Optional macro SEQ_DIV0_TRAP_EN turns a divide by zero into a trap-halt.
module cpu_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [15:0]     imem_data,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [2:0]      alu_op,
  input  logic [7:0]      alu_result,
  input  logic            alu_carry,
  output logic            carry_flag,
  output logic            wb_valid,
  output logic [1:0]      wb_rd,
  output logic [7:0]      wb_data,
  output logic            halted,
  output logic            trap,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

`ifdef SEQ_DIV0_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  // Memory handshake: an instruction transfers on a rising edge where imem_req
  // and imem_valid are both high; imem_req and imem_addr stay fixed until then.
  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [15:0]       ir;
  logic [7:0]        regs [4];
  logic              wb_carry;
  logic              trap_hit;

  assign imem_addr = pc;
  assign dbg_state = state;
  assign trap_hit  = TRAP_EN && (alu_op == 3'b110) && (alu_b == 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      ir         <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      wb_carry   <= 1'b0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      carry_flag <= 1'b0;
      imem_req   <= 1'b0;
      halted     <= 1'b0;
      trap       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_valid) begin
            ir       <= imem_data;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!ir[15]) begin
            alu_a  <= regs[ir[9:8]];
            alu_b  <= regs[ir[7:6]];
            alu_op <= ir[14:12];
            wb_rd  <= ir[11:10];
            state  <= S_EXECUTE;
          end else begin
            case (ir[14:12])
              3'b000: begin
                wb_rd    <= ir[11:10];
                wb_data  <= ir[7:0];
                wb_valid <= 1'b1;
                state    <= S_WRITEBACK;
              end
              3'b111: begin
                halted <= 1'b1;
                state  <= S_HALT;
              end
              default: begin
                pc       <= pc + 1'b1;
                imem_req <= 1'b1;
                state    <= S_FETCH;
              end
            endcase
          end
        end
        S_EXECUTE: begin
          if (trap_hit) begin
            // Trapped divide leaves PC on the faulting instruction.
            trap   <= 1'b1;
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            wb_data  <= alu_result;
            wb_carry <= alu_carry;
            wb_valid <= 1'b1;
            state    <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          regs[wb_rd] <= wb_data;
          if (!ir[15]) carry_flag <= wb_carry;
          pc       <= pc + 1'b1;
          wb_valid <= 1'b0;
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        S_HALT: begin
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
